// File: rtl/lsu_mmio_pkg.sv
// Shared encodings, address map and lane helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam int OUT_BASE = 'h800;
    localparam int IN_BASE  = 'h900;

    function automatic logic rwsel_legal(input logic [2:0] rw);
        return rw inside {RW_B, RW_H, RW_W, RW_BU, RW_HU};
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] rw, input logic [1:0] lane);
        case (rw)
            RW_B, RW_BU: return 4'b0001 << lane;
            RW_H, RW_HU: return lane[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across the word so every enabled lane sees it.
    function automatic logic [31:0] store_data(input logic [2:0] rw, input logic [31:0] sd);
        case (rw)
            RW_B, RW_BU: return {4{sd[7:0]}};
            RW_H, RW_HU: return {2{sd[15:0]}};
            default:     return sd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] rw,
                                                input logic [1:0] lane);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        case (rw)
            RW_B:    return {{24{sh[7]}}, sh[7:0]};
            RW_BU:   return {24'b0, sh[7:0]};
            RW_H:    return {{16{sh[15]}}, sh[15:0]};
            RW_HU:   return {16'b0, sh[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mmio_if.sv
// Request/response handshake between the EX/MEM stage and the load/store unit.
interface lsu_mmio_if #(parameter int ADDR_W = 12);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_sdata;
    logic [2:0]        req_rwsel;
    logic              resp_valid;
    logic [31:0]       resp_ldata;
    logic              resp_err;

    modport master (output req_valid, req_we, req_addr, req_sdata, req_rwsel,
                    input  req_ready, resp_valid, resp_ldata, resp_err);
    modport slave  (input  req_valid, req_we, req_addr, req_sdata, req_rwsel,
                    output req_ready, resp_valid, resp_ldata, resp_err);
endinterface

// File: rtl/lsu_mmio_dmem_sram.sv
// Byte-enabled word RAM, write-first, with an RD_LAT-deep registered read pipeline.
// Read data for an access at edge T appears on rdata RD_LAT cycles later.
module dmem_sram #(
    parameter int WORDS  = 512,
    parameter int AW     = 9,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem  [WORDS];
    logic [31:0] pipe [RD_LAT];
    logic [31:0] merged;

    always_comb begin
        merged = mem[addr];
        for (int b = 0; b < 4; b++)
            if (we && be[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++)
                if (we && be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            pipe[0] <= merged;
        end
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign rdata = pipe[RD_LAT-1];
endmodule

// File: rtl/lsu_mmio.sv
// Memory-stage load/store unit serving DMEM and memory-mapped IO registers.
// DMEM loads respond after RD_LAT cycles (ready low while waiting); all else after 1.
module lsu_mmio
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DMEM_WORDS = 512,
    parameter int RD_LAT     = 1,
    parameter int N_OUT      = 11,
    parameter int N_IN       = 2
) (
    input  logic               clk,
    input  logic               rst,
    lsu_mmio_if.slave          bus,
    input  logic [N_IN*32-1:0] in_raw,
    output logic [N_OUT*32-1:0] out_regs
);
    localparam int DW_AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam logic [31:0] OUT_LO = 32'(OUT_BASE);
    localparam logic [31:0] OUT_HI = 32'(OUT_BASE + 4*N_OUT);
    localparam logic [31:0] IN_LO  = 32'(IN_BASE);
    localparam logic [31:0] IN_HI  = 32'(IN_BASE + 4*N_IN);

    state_t      state;
    logic [2:0]  cnt;
    logic [1:0]  lane_q;
    logic [2:0]  rw_q;
    logic        dmem_ld_q, err_q;
    logic [31:0] ldata_q;
    logic [31:0] out_q [N_OUT];
    logic [N_IN*32-1:0] sync1, sync2;

    logic [ADDR_W-1:0] addr;
    logic [31:0] addr32, out_off, in_off, io_word, wdata, rdata;
    logic [2:0]  rw;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic        dmem_hit, out_hit, in_hit, misalign, err, acc, ok, resp_vld;

    assign addr    = bus.req_addr;
    assign addr32  = 32'(addr);
    assign rw      = bus.req_rwsel;
    assign lane    = addr[1:0];
    assign out_off = (addr32 - OUT_LO) >> 2;
    assign in_off  = (addr32 - IN_LO) >> 2;

    assign dmem_hit = !addr[ADDR_W-1] && ((addr32 >> 2) < 32'(DMEM_WORDS));
    assign out_hit  = (addr32 >= OUT_LO) && (addr32 < OUT_HI);
    assign in_hit   = (addr32 >= IN_LO) && (addr32 < IN_HI);
    assign misalign = (rw[1:0] == 2'b01 && addr[0]) || (rw[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign err      = !rwsel_legal(rw) || misalign || !(dmem_hit || out_hit || in_hit)
                    || (bus.req_we && in_hit);

    assign bus.req_ready = (state != ST_WAIT);
    assign acc   = bus.req_valid && bus.req_ready;
    assign ok    = acc && !err;
    assign be    = byte_en(rw, lane);
    assign wdata = store_data(rw, bus.req_sdata);

    always_comb begin
        io_word = '0;
        for (int i = 0; i < N_OUT; i++)
            if (out_hit && out_off == 32'(i)) io_word = out_q[i];
        for (int j = 0; j < N_IN; j++)
            if (in_hit && in_off == 32'(j)) io_word = sync2[32*j +: 32];
    end

    dmem_sram #(.WORDS(DMEM_WORDS), .AW(DW_AW), .RD_LAT(RD_LAT)) u_dmem (
        .clk   (clk),
        .en    (ok && dmem_hit),
        .we    (bus.req_we),
        .be    (be),
        .addr  (addr[DW_AW+1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lane_q    <= '0;
            rw_q      <= '0;
            dmem_ld_q <= 1'b0;
            err_q     <= 1'b0;
            ldata_q   <= '0;
            sync1     <= '0;
            sync2     <= '0;
            for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
        end else begin
            sync1 <= in_raw;
            sync2 <= sync1;
            case (state)
                ST_WAIT: begin
                    if (cnt <= 3'd1) state <= ST_RESP;
                    else             cnt   <= cnt - 3'd1;
                end
                default: begin
                    if (acc) begin
                        lane_q    <= lane;
                        rw_q      <= rw;
                        err_q     <= err;
                        dmem_ld_q <= ok && dmem_hit && !bus.req_we;
                        // IO load data is snapped now; DMEM data arrives through the RAM pipe.
                        ldata_q   <= (ok && !bus.req_we && !dmem_hit) ?
                                     load_extend(io_word, rw, lane) : '0;
                        if (ok && dmem_hit && !bus.req_we && RD_LAT > 1) begin
                            state <= ST_WAIT;
                            cnt   <= 3'(RD_LAT - 1);
                        end else begin
                            state <= ST_RESP;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
            for (int i = 0; i < N_OUT; i++)
                if (ok && bus.req_we && out_hit && out_off == 32'(i))
                    for (int b = 0; b < 4; b++)
                        if (be[b]) out_q[i][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign resp_vld       = (state == ST_RESP);
    assign bus.resp_valid = resp_vld;
    assign bus.resp_err   = resp_vld && err_q;
    assign bus.resp_ldata = !resp_vld ? '0 :
                            dmem_ld_q ? load_extend(rdata, rw_q, lane_q) : ldata_q;

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_regs[32*g +: 32] = out_q[g];
    end
endmodule

// File: tb/tb_lsu_mmio.sv
// Randomised and directed bench for lsu_mmio with a byte-level reference model and response scoreboard.
module tb_lsu_mmio;
    import lsu_pkg::*;

    localparam int ADDR_W = 12, DMEM_WORDS = 256, RD_LAT = 3, N_OUT = 11, N_IN = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N_IN*32-1:0]  in_raw;
    wire  [N_OUT*32-1:0] out_regs;

    always #5 clk = ~clk;

    lsu_mmio_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_mmio #(.ADDR_W(ADDR_W), .DMEM_WORDS(DMEM_WORDS), .RD_LAT(RD_LAT),
               .N_OUT(N_OUT), .N_IN(N_IN)) dut (
        .clk(clk), .rst(rst), .bus(bus), .in_raw(in_raw), .out_regs(out_regs));

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0, bad = 0;

    typedef struct { logic [31:0] ld; logic err; int due; } exp_t;
    exp_t expq[$];

    logic [7:0]  dm_b  [DMEM_WORDS*4];
    logic [7:0]  out_b [N_OUT*4];
    logic [31:0] in_cur [N_IN];
    logic [31:0] in_old [N_IN];
    int          in_chg [N_IN];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_out(input string nm);
        logic [N_OUT*32-1:0] want;
        for (int i = 0; i < N_OUT*4; i++) want[8*i +: 8] = out_b[i];
        total++;
        if (out_regs !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, out_regs, want);
        end
    endtask

    // Synchronised view: a change becomes visible to loads accepted two or more cycles later.
    function automatic logic [31:0] in_word(input int j);
        return (cyc - in_chg[j] >= 2) ? in_cur[j] : in_old[j];
    endfunction

    function automatic logic [7:0] rd_byte(input int a, input int region);
        logic [31:0] w;
        if (region == 0) return dm_b[a];
        if (region == 1) return out_b[a - 'h800];
        w = in_word((a - 'h900) / 4);
        return w[8*(a%4) +: 8];
    endfunction

    task automatic model_issue(input logic we, input int a, input logic [31:0] sd, input logic [2:0] rw);
        exp_t e;
        int sz, region;
        logic ill, er;
        logic [31:0] v;
        ill = !(rw inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        sz  = (rw[1:0] == 2'b00) ? 1 : (rw[1:0] == 2'b01) ? 2 : 4;
        if (a < 'h800)                                region = (a/4 < DMEM_WORDS) ? 0 : 3;
        else if (a >= 'h800 && a < 'h800 + 4*N_OUT)   region = 1;
        else if (a >= 'h900 && a < 'h900 + 4*N_IN)    region = 2;
        else                                          region = 3;
        er = ill || (a % sz != 0) || region == 3 || (we && region == 2);
        v = '0;
        e.due = cyc + 1;
        if (!er && we) begin
            for (int k = 0; k < sz; k++) begin
                if (region == 0) dm_b[a+k] = sd[8*k +: 8];
                else             out_b[a+k-'h800] = sd[8*k +: 8];
            end
        end else if (!er) begin
            for (int k = 0; k < sz; k++) v[8*k +: 8] = rd_byte(a+k, region);
            if (!rw[2] && sz == 1 && v[7])  v[31:8]  = '1;
            if (!rw[2] && sz == 2 && v[15]) v[31:16] = '1;
            if (region == 0) e.due = cyc + RD_LAT;
        end
        e.ld  = v;
        e.err = er;
        expq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drop();
        bus.req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input int a, input logic [31:0] sd, input logic [2:0] rw,
                          output int t);
        int budget;
        budget = 0;
        bus.req_we = we; bus.req_addr = a[ADDR_W-1:0]; bus.req_sdata = sd; bus.req_rwsel = rw;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && budget < 20) begin step(); budget++; end
        if (!bus.req_ready) begin
            total++; bad++;
            $display("FAIL req_ready_timeout addr=%h", a);
            drop();
            t = -1;
        end else begin
            t = cyc;
            model_issue(we, a, sd, rw);
            step();
        end
    endtask

    task automatic set_in(input int j, input logic [31:0] v);
        drop();
        while (cyc - in_chg[j] < 2) step();
        in_old[j] = in_cur[j];
        in_cur[j] = v;
        in_chg[j] = cyc;
        in_raw[32*j +: 32] = v;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            while (expq.size() > 0 && expq[0].due < cyc) begin
                total++; bad++;
                $display("FAIL missing_resp due=%0d now=%0d", expq[0].due, cyc);
                void'(expq.pop_front());
            end
            if (bus.resp_valid) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp got=valid want=idle cycle=%0d", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("resp_ldata", bus.resp_ldata, e.ld);
                    chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                    chk("resp_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin
        int t1, t2, a, r;
        logic [2:0] rw;
        in_raw = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_sdata = '0;   bus.req_rwsel = RW_W;
        for (int i = 0; i < N_OUT*4; i++) out_b[i] = 8'h00;
        for (int j = 0; j < N_IN; j++) begin in_cur[j] = '0; in_old[j] = '0; in_chg[j] = -10; end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk_out("reset_out_regs");
        rst = 1'b1;
        step();

        // Store then load, with the WAIT window visible on req_ready.
        do_req(1'b1, 'h010, 32'hDEADBEEF, RW_W, t1);
        do_req(1'b0, 'h010, 32'h0, RW_W, t1);
        drop();
        chk("wait_ready_1", 32'(bus.req_ready), 32'd0);
        step();
        chk("wait_ready_2", 32'(bus.req_ready), 32'd0);
        step();
        chk("resp_ready", 32'(bus.req_ready), 32'd1);

        do_req(1'b1, 'h013, 32'h00000080, RW_B,  t1);
        do_req(1'b0, 'h013, 32'h0,        RW_B,  t1);
        do_req(1'b0, 'h013, 32'h0,        RW_BU, t1);
        do_req(1'b0, 'h012, 32'h0,        RW_H,  t1);
        do_req(1'b0, 'h012, 32'h0,        RW_W,  t1);
        do_req(1'b1, 'h011, 32'h0000FFFF, RW_H,  t1);
        do_req(1'b0, 'h010, 32'h0,        RW_W,  t1);

        do_req(1'b1, 'h804, 32'h12345678, RW_W, t1);
        drop();
        chk_out("out_sw");
        do_req(1'b1, 'h806, 32'h000000AA, RW_B, t1);
        drop();
        chk_out("out_sb");
        chk("out_word1", out_regs[63:32], 32'h12AA5678);
        do_req(1'b0, 'h806, 32'h0, RW_HU, t1);

        // Synchroniser: one cycle after the change still old, later new.
        set_in(0, 32'h000000F0);
        step();
        do_req(1'b0, 'h900, 32'h0, RW_W, t1);
        drop();
        step();
        do_req(1'b0, 'h900, 32'h0, RW_W, t1);
        do_req(1'b1, 'h900, 32'h55, RW_W, t1);

        // Back-to-back accept with req_valid held high.
        do_req(1'b1, 'h020, 32'hCAFEF00D, RW_W, t1);
        do_req(1'b0, 'h020, 32'h0,        RW_W, t2);
        drop();
        chk("b2b_accept_gap", 32'(t2 - t1), 32'd1);

        // Map boundaries and illegal encodings.
        do_req(1'b1, 'h3FC, 32'hA5A5C3C3, RW_W, t1);
        do_req(1'b0, 'h3FE, 32'h0, RW_H, t1);
        do_req(1'b0, 'h400, 32'h0, RW_W, t1);
        do_req(1'b1, 'h828, 32'h87654321, RW_W, t1);
        do_req(1'b0, 'h828, 32'h0, RW_W, t1);
        do_req(1'b1, 'h82C, 32'h1, RW_W, t1);
        do_req(1'b0, 'h904, 32'h0, RW_W, t1);
        do_req(1'b0, 'h908, 32'h0, RW_W, t1);
        do_req(1'b0, 'h010, 32'h0, 3'b011, t1);
        do_req(1'b1, 'h010, 32'h0, 3'b110, t1);
        do_req(1'b0, 'h010, 32'h0, 3'b111, t1);
        drop();
        chk_out("out_after_boundary");

        for (int w = 0; w < 16; w++) do_req(1'b1, 4*w, $urandom, RW_W, t1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) set_in($urandom_range(0, N_IN-1), $urandom);
            if ($urandom_range(0, 2) == 0) begin drop(); step(); end
            r = $urandom_range(0, 9);
            if (r <= 4)      a = $urandom_range(0, 63);
            else if (r <= 6) a = 'h800 + $urandom_range(0, 4*N_OUT + 3);
            else if (r == 7) a = 'h900 + $urandom_range(0, 11);
            else if (r == 8) a = 'h400 + $urandom_range(0, 'h3FF);
            else             a = 'hA00 + $urandom_range(0, 'h5FF);
            rw = 3'($urandom_range(0, 7));
            do_req(1'($urandom_range(0, 1)), a, $urandom, rw, t1);
            if (n % 25 == 0) begin drop(); chk_out("out_random"); end
        end

        // Reset while a DMEM load is waiting: the load is abandoned.
        drop();
        step();
        do_req(1'b0, 'h014, 32'h0, RW_W, t1);
        drop();
        rst = 1'b0;
        expq.delete();
        for (int i = 0; i < N_OUT*4; i++) out_b[i] = 8'h00;
        #1;
        chk("midwait_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("midwait_rst_resp", 32'(bus.resp_valid), 32'd0);
        chk_out("midwait_rst_out");
        step();
        step();
        rst = 1'b1;
        for (int j = 0; j < N_IN; j++) begin in_old[j] = '0; in_chg[j] = cyc; end
        step();
        step();
        do_req(1'b0, 'h010, 32'h0, RW_W, t1);
        do_req(1'b0, 'h904, 32'h0, RW_W, t1);
        do_req(1'b0, 'h804, 32'h0, RW_W, t1);

        drop();
        repeat (RD_LAT + 3) step();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain_queue got=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
